// File: rtl/led_catcher_core.sv
// LED catcher game engine: lights a random target lane, scores hits in packed BCD,
// and charges a life on a timeout or a wrong switch. Difficulty halves the window.
module led_catcher_core #(
    parameter int          N_LEDS        = 16,
    parameter int          WINDOW_CYCLES = 100_000_000,
    parameter int          MAX_LEVEL     = 3,
    parameter int          LIVES         = 3,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_LEDS-1:0] switch,
    output logic [N_LEDS-1:0] state,
    output logic [15:0]       BCD,
    output logic [2:0]        lives,
    output logic [1:0]        level,
    output logic              game_over
);

    localparam int             TW         = $clog2(WINDOW_CYCLES + 1);
    localparam logic [TW-1:0]  WIN0       = TW'(WINDOW_CYCLES);
    localparam logic [TW-1:0]  ONE        = TW'(1);
    localparam logic [1:0]     LVL_MAX    = 2'(MAX_LEVEL);
    localparam logic [2:0]     LIVES_INIT = 3'(LIVES);
    localparam logic [3:0]     LAST_LANE  = 4'(N_LEDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_WAIT,
        S_HIT,
        S_MISS,
        S_OVER
    } fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic              start_s1_q, start_s2_q, start_s3_q;
    logic [N_LEDS-1:0] sw_s1_q, sw_s2_q, sw_s3_q;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [N_LEDS-1:0] led_q, led_d;
    logic [15:0]       bcd_q, bcd_d;
    logic [2:0]        lives_q, lives_d;
    logic [1:0]        level_q, level_d;
    logic              over_q, over_d;
    logic [3:0]        tgt_q, tgt_d;
    logic [TW-1:0]     timer_q, timer_d;

    logic              start_ev;
    logic [N_LEDS-1:0] lane_ev;
    logic              hit_ev, wrong_ev;
    logic [3:0]        spawn_raw, spawn_idx;
    logic [15:0]       bcd_inc;
    logic              carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_s1_q <= 1'b0;
            start_s2_q <= 1'b0;
            start_s3_q <= 1'b0;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            sw_s3_q    <= '0;
            lfsr_q     <= LFSR_SEED;
            fsm_q      <= S_IDLE;
            led_q      <= '0;
            bcd_q      <= '0;
            lives_q    <= LIVES_INIT;
            level_q    <= '0;
            over_q     <= 1'b0;
            tgt_q      <= '0;
            timer_q    <= '0;
        end else begin
            start_s1_q <= start;
            start_s2_q <= start_s1_q;
            start_s3_q <= start_s2_q;
            sw_s1_q    <= switch;
            sw_s2_q    <= sw_s1_q;
            sw_s3_q    <= sw_s2_q;
            lfsr_q     <= lfsr_d;
            fsm_q      <= fsm_d;
            led_q      <= led_d;
            bcd_q      <= bcd_d;
            lives_q    <= lives_d;
            level_q    <= level_d;
            over_q     <= over_d;
            tgt_q      <= tgt_d;
            timer_q    <= timer_d;
        end
    end

    assign start_ev = start_s2_q & ~start_s3_q;
    assign lane_ev  = sw_s2_q ^ sw_s3_q;
    // In WAIT led_q holds exactly the target one-hot, so it doubles as the lane mask.
    assign hit_ev   = |(lane_ev & led_q);
    assign wrong_ev = |(lane_ev & ~led_q);

    always_comb begin
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        spawn_raw = 4'(lfsr_q % 16'(N_LEDS));
        spawn_idx = spawn_raw;
        if (spawn_raw == tgt_q) begin
            spawn_idx = (spawn_raw == LAST_LANE) ? 4'd0 : spawn_raw + 4'd1;
        end
    end

    always_comb begin
        bcd_inc = bcd_q;
        carry   = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (bcd_inc[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd_inc[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        led_d   = led_q;
        bcd_d   = bcd_q;
        lives_d = lives_q;
        level_d = level_q;
        over_d  = over_q;
        tgt_d   = tgt_q;
        timer_d = timer_q;
        case (fsm_q)
            S_IDLE, S_OVER: begin
                if (start_ev) begin
                    bcd_d   = '0;
                    lives_d = LIVES_INIT;
                    level_d = '0;
                    over_d  = 1'b0;
                    led_d   = '0;
                    fsm_d   = S_SPAWN;
                end
            end
            S_SPAWN: begin
                tgt_d   = spawn_idx;
                led_d   = {{(N_LEDS-1){1'b0}}, 1'b1} << spawn_idx;
                timer_d = (WIN0 >> level_q) - ONE;
                fsm_d   = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q - ONE;
                if (wrong_ev) begin
                    fsm_d = S_MISS;
                end else if (hit_ev) begin
                    fsm_d = S_HIT;
                end else if (timer_q == '0) begin
                    fsm_d = S_MISS;
                end
            end
            S_HIT: begin
                if (bcd_q != 16'h9999) begin
                    bcd_d = bcd_inc;
                    if (bcd_q[3:0] == 4'd9 && level_q != LVL_MAX) begin
                        level_d = level_q + 2'd1;
                    end
                end
                fsm_d = S_SPAWN;
            end
            S_MISS: begin
                lives_d = lives_q - 3'd1;
                if (lives_q == 3'd1) begin
                    led_d  = '1;
                    over_d = 1'b1;
                    fsm_d  = S_OVER;
                end else begin
                    led_d  = '0;
                    fsm_d  = S_SPAWN;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    assign state     = led_q;
    assign BCD       = bcd_q;
    assign lives     = lives_q;
    assign level     = level_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_led_catcher_core.sv
// Directed bench for led_catcher_core: a 16-lane instance (window 32) and a
// 5-lane instance (window 8) driven through a shared set of stimulus tasks.
module tb_led_catcher_core;

    localparam int W0 = 32;
    localparam int W1 = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [15:0] sw0;
    logic [4:0]  sw1;
    logic [15:0] st0, bcd0, bcd1;
    logic [4:0]  st1;
    logic [2:0]  lives0, lives1;
    logic [1:0]  lvl0, lvl1;
    logic        go0, go1;

    always #5 clk = ~clk;

    led_catcher_core #(.N_LEDS(16), .WINDOW_CYCLES(W0), .MAX_LEVEL(3), .LIVES(3),
                       .LFSR_SEED(16'hACE1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .switch(sw0), .state(st0),
        .BCD(bcd0), .lives(lives0), .level(lvl0), .game_over(go0));

    led_catcher_core #(.N_LEDS(5), .WINDOW_CYCLES(W1), .MAX_LEVEL(3), .LIVES(3),
                       .LFSR_SEED(16'h1D2B)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .switch(sw1), .state(st1),
        .BCD(bcd1), .lives(lives1), .level(lvl1), .game_over(go1));

    typedef enum int {OP_START, OP_HIT, OP_TO, OP_IDLE} op_e;
    typedef struct {
        op_e         op;
        int          n;
        logic [15:0] bcd;
        logic [2:0]  lives;
        logic [1:0]  lvl;
        logic        go;
    } vec_t;

    vec_t        tbl [12];
    int          checks = 0;
    int          errors = 0;
    int          sel = 0;
    logic [15:0] prev [2];

    function automatic logic [15:0] cur_st();
        return (sel == 0) ? st0 : {11'b0, st1};
    endfunction
    function automatic logic [15:0] cur_bcd();
        return (sel == 0) ? bcd0 : bcd1;
    endfunction
    function automatic logic [2:0] cur_lives();
        return (sel == 0) ? lives0 : lives1;
    endfunction
    function automatic logic [1:0] cur_lvl();
        return (sel == 0) ? lvl0 : lvl1;
    endfunction
    function automatic logic cur_go();
        return (sel == 0) ? go0 : go1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic toggle(input int lane);
        if (sel == 0) sw0[lane[3:0]] = ~sw0[lane[3:0]];
        else          sw1[lane[2:0]] = ~sw1[lane[2:0]];
    endtask

    // Leaves the bench one edge before the first target appears.
    task automatic do_start();
        @(negedge clk);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (sel == 0) start0 = 1'b0; else start1 = 1'b0;
    endtask

    task automatic next_target(output int t);
        logic [15:0] s;
        @(posedge clk);
        #1;
        s = cur_st();
        chk("target_onehot", 32'($countones(s)), 32'd1);
        chk("target_differs", {31'b0, s != prev[sel]}, 32'd1);
        prev[sel] = s;
        t = 0;
        for (int i = 0; i < 16; i++) if (s[i]) t = i;
    endtask

    task automatic do_hit();
        int t;
        next_target(t);
        @(negedge clk);
        toggle(t);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_timeout(output int len);
        int t;
        int n;
        logic [2:0] l0;
        next_target(t);
        l0 = cur_lives();
        n  = 0;
        while (cur_lives() == l0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        len = n - 1;
    endtask

    task automatic do_idle();
        repeat (10) begin
            @(negedge clk);
            toggle(0);
            toggle(5);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t, len, spawns, iter;

        tbl[0]  = '{OP_START, 0,  16'h0000, 3'd3, 2'd0, 1'b0};
        tbl[1]  = '{OP_HIT,   1,  16'h0001, 3'd3, 2'd0, 1'b0};
        tbl[2]  = '{OP_HIT,   9,  16'h0010, 3'd3, 2'd1, 1'b0};
        tbl[3]  = '{OP_TO,    1,  16'h0010, 3'd2, 2'd1, 1'b0};
        tbl[4]  = '{OP_HIT,   10, 16'h0020, 3'd2, 2'd2, 1'b0};
        tbl[5]  = '{OP_HIT,   10, 16'h0030, 3'd2, 2'd3, 1'b0};
        tbl[6]  = '{OP_TO,    1,  16'h0030, 3'd1, 2'd3, 1'b0};
        tbl[7]  = '{OP_HIT,   10, 16'h0040, 3'd1, 2'd3, 1'b0};
        tbl[8]  = '{OP_HIT,   60, 16'h0100, 3'd1, 2'd3, 1'b0};
        tbl[9]  = '{OP_TO,    1,  16'h0100, 3'd0, 2'd3, 1'b1};
        tbl[10] = '{OP_IDLE,  0,  16'h0100, 3'd0, 2'd3, 1'b1};
        tbl[11] = '{OP_START, 0,  16'h0000, 3'd3, 2'd0, 1'b0};

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; sw0 = '0; sw1 = '0;
        prev[0] = '0; prev[1] = '0;
        #12;
        sel = 0;
        chk("rst_state", 32'(cur_st()), 32'h0);
        chk("rst_bcd", 32'(cur_bcd()), 32'h0);
        chk("rst_lives", 32'(cur_lives()), 32'd3);
        chk("rst_level", 32'(cur_lvl()), 32'd0);
        chk("rst_over", 32'(cur_go()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 5-lane instance: level-up at ten hits, halved window, then a long spawn run.
        sel = 1;
        do_start();
        repeat (10) do_hit();
        chk("n5_bcd10", 32'(cur_bcd()), 32'h0010);
        chk("n5_level1", 32'(cur_lvl()), 32'd1);
        do_timeout(len);
        chk("n5_wait_len_l1", 32'(len), 32'(W1 >> 1));
        chk("n5_lives2", 32'(cur_lives()), 32'd2);
        spawns = 0;
        iter = 0;
        while (spawns < 200 && iter < 1000) begin
            iter++;
            if (cur_go()) begin
                do_start();
            end else if (cur_lvl() < 2'd2) begin
                do_hit();
                spawns++;
            end else begin
                do_timeout(len);
                spawns++;
            end
        end
        chk("n5_spawn_count", 32'(spawns), 32'd200);

        sel = 0;
        for (int i = 0; i < 12; i++) begin
            case (tbl[i].op)
                OP_START: do_start();
                OP_HIT:   repeat (tbl[i].n) do_hit();
                OP_TO: begin
                    do_timeout(len);
                    chk($sformatf("vec%0d_wait_len", i), 32'(len), 32'(W0 >> tbl[i].lvl));
                end
                default:  do_idle();
            endcase
            chk($sformatf("vec%0d_bcd", i), 32'(cur_bcd()), 32'(tbl[i].bcd));
            chk($sformatf("vec%0d_lives", i), 32'(cur_lives()), 32'(tbl[i].lives));
            chk($sformatf("vec%0d_level", i), 32'(cur_lvl()), 32'(tbl[i].lvl));
            chk($sformatf("vec%0d_over", i), 32'(cur_go()), 32'(tbl[i].go));
            if (tbl[i].go) chk($sformatf("vec%0d_state", i), 32'(cur_st()), 32'hFFFF);
        end

        // Target and wrong lane together; later toggles land in MISS and SPAWN.
        next_target(t);
        @(negedge clk);
        toggle(t);
        toggle((t + 1) % 16);
        @(negedge clk);
        toggle((t + 2) % 16);
        @(negedge clk);
        toggle((t + 3) % 16);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("simul_lives", 32'(cur_lives()), 32'd2);
        chk("simul_bcd", 32'(cur_bcd()), 32'h0);
        do_timeout(len);
        chk("after_miss_wait_len", 32'(len), 32'(W0));
        chk("after_miss_lives", 32'(cur_lives()), 32'd1);
        do_hit();
        chk("after_miss_hit_bcd", 32'(cur_bcd()), 32'h0001);
        repeat (4) do_hit();
        chk("pre_reset_bcd", 32'(cur_bcd()), 32'h0005);

        // Asynchronous reset in the middle of WAIT, checked before any clock edge.
        next_target(t);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(cur_st()), 32'h0);
        chk("async_rst_bcd", 32'(cur_bcd()), 32'h0);
        chk("async_rst_lives", 32'(cur_lives()), 32'd3);
        chk("async_rst_level", 32'(cur_lvl()), 32'd0);
        chk("async_rst_over", 32'(cur_go()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev[0] = '0;
        prev[1] = '0;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_state", 32'(cur_st()), 32'h0);
        chk("idle_bcd", 32'(cur_bcd()), 32'h0);
        do_start();
        do_hit();
        chk("restart_hit_bcd", 32'(cur_bcd()), 32'h0001);
        chk("restart_hit_lives", 32'(cur_lives()), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
